icache_axi_refill: RTL
======================

Name: icache_axi_refill

Overview:
- Memory-side responder for the instruction-cache line-refill interface.
- Accepts a 64-byte line read request from the I-cache and issues one AXI4 INCR read burst of 16×32-bit beats.
- Returns the beats as the `mmu_valid` / `mmu_last` stream the cache consumes. The stream has no backpressure.
- Sits between the I-cache and the AXI read channel of the system interconnect. It guarantees exactly 16 beats per accepted request, even when the AXI slave misbehaves.

Parameters:
- `ID_WIDTH`, 4, width of `arid` / `rid`.
- `ARID_VAL`, 0, constant ID driven on `arid`.
- `BEATS`, 16, beats per line. Fixed at 16; the counter is 4 bits.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_addr_mmu`  in  32  line address from the cache; bits [5:0] are 0.
- `inst_read_req`  in  1  refill request. Held high with a stable address until `inst_addr_ok` is seen.
- `inst_addr_ok`  out  1  one-cycle request-accept pulse.
- `inst_read_data`  out  32  returned beat data.
- `mmu_valid`  out  1  beat valid, one cycle per beat.
- `mmu_last`  out  1  marks beat 16 of 16.
- `arid`  out  `ID_WIDTH`  = `ARID_VAL`.
- `araddr`  out  32  latched line address with [5:0] forced to 0.
- `arlen`  out  8  constant 15.
- `arsize`  out  3  constant 3'b010.
- `arburst`  out  2  constant 2'b01 (INCR).
- `arcache`  out  4  constant 4'b0000.
- `arprot`  out  3  constant 3'b100.
- `arvalid`  out  1  AR valid.
- `arready`  in  1  AR ready.
- `rid`  in  `ID_WIDTH`  ignored.
- `rdata`  in  32  R data.
- `rresp`  in  2  R response.
- `rlast`  in  1  R last.
- `rvalid`  in  1  R valid.
- `rready`  out  1  R ready.
- `refill_err_resp`  out  1  sticky: some beat returned a non-OKAY `rresp`.
- `refill_err_len`  out  1  sticky: burst length was not 16 beats.

Behaviour:
- Reset (`rst` = 1 at a clock edge):
  - state goes to IDLE;
  - `inst_addr_ok`, `mmu_valid`, `mmu_last`, `arvalid`, `rready`, `refill_err_*` all 0;
  - `inst_read_data` 0; beat counter 0; `araddr` 0.
  - Reset mid-operation abandons the burst immediately and emits no further beats. The interconnect is reset by the same `rst`.
- State IDLE:
  - `rready` = 0.
  - If `inst_read_req` = 1: latch `{inst_addr_mmu[31:6], 6'b0}` into `araddr`, clear the beat counter, go to ARQ.
- State ARQ:
  - `arvalid` = 1.
  - `inst_addr_ok` = 1 for exactly the first cycle in ARQ. This is a registered pulse, one cycle after the request was sampled, and is never repeated for the same request.
  - `arvalid` is held until `arready`; `araddr` is stable while `arvalid` is high.
  - On `arvalid && arready`: go to RD.
- State RD:
  - `rready` = 1.
  - On each `rvalid` beat, the following cycle has `mmu_valid` = 1 and `inst_read_data` = `rdata`. Data latency is 1 cycle from the R handshake.
  - `mmu_last` = 1 on the beat where counter = 15; the counter increments per beat.
  - Normal end (`rlast` with counter 15): emit the last beat, go to IDLE.
  - Early `rlast` (counter < 15): forward that beat, set `refill_err_len`, go to PAD.
  - Counter = 15 without `rlast`: forward it with `mmu_last`, set `refill_err_len`, go to DRAIN.
- State PAD:
  - `rready` = 0.
  - One zero-data beat (`mmu_valid` = 1, `inst_read_data` = 0) is emitted per cycle until beat 16, which carries `mmu_last`. Then go to IDLE.
- State DRAIN:
  - `rready` = 1; beats are consumed and discarded, with no `mmu_valid`.
  - Go to IDLE after the beat with `rlast`.
- Any beat with `rresp` ≠ 2'b00: set `refill_err_resp`. The data is still forwarded.
- Sticky error bits are cleared only by `rst`.
- Exactly one outstanding burst at a time. `inst_read_req` is ignored outside IDLE.
- `inst_read_req` seen in the same cycle the FSM enters IDLE is accepted on the next edge. A back-to-back refill has a minimum gap of 1 IDLE cycle.
- `mmu_valid` and `mmu_last` are never asserted outside RD/PAD output cycles. Exactly 16 `mmu_valid` pulses and 1 `mmu_last` occur per accepted request.

Test Plan:
- Nominal refill: req addr 0x1FC0_0040; `arready` immediate; `rdata` = k+0xA0, k = 0..15, back-to-back → `inst_addr_ok` one pulse; `araddr` = 0x1FC0_0040, `arlen` = 15; 16 `mmu_valid` with data 0xA0..0xAF; `mmu_last` on 0xAF; no errors.
- AR backpressure plus R gaps: `arready` low 5 cycles; `rvalid` every 3rd cycle → `arvalid` and `araddr` stable 6 cycles; `inst_addr_ok` still a single pulse; 16 beats in order, each 1 cycle after its handshake.
- Short burst: `rlast` on beat 10 → beats 1–10 carry data, beats 11–16 carry data 0, `mmu_last` on 16; `refill_err_len` = 1.
- Long burst: 20 beats, `rlast` on 20 → `mmu_last` on beat 16; beats 17–20 absorbed with `rready` = 1 and no `mmu_valid`; `refill_err_len` = 1; next request accepted afterwards.
- `rresp` = 2'b10 on beat 3 → data forwarded unchanged; `refill_err_resp` = 1 and stays set through a following clean refill.
- `rst` asserted after beat 7 → next cycle all outputs 0, state IDLE, sticky bits 0; a new request then completes a normal 16-beat refill.

Source files
------------

// File: rtl/icache_axi_refill.sv
// I-cache line refill responder: one 64-byte request becomes one 16-beat AXI4 INCR read burst.
// Latency: inst_addr_ok one cycle after the request is sampled; each beat leaves one cycle after its R handshake.
// Backpressure: AR waits for arready; the beat stream to the cache has none, and short/long bursts are padded/drained to 16 beats.
module icache_axi_refill #(
   parameter int          ID_WIDTH = 4,
   parameter int unsigned ARID_VAL = 0,
   parameter int          BEATS    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         inst_addr_mmu,
   input  logic                inst_read_req,
   output logic                inst_addr_ok,
   output logic [31:0]         inst_read_data,
   output logic                mmu_valid,
   output logic                mmu_last,
   output logic [ID_WIDTH-1:0] arid,
   output logic [31:0]         araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic [3:0]          arcache,
   output logic [2:0]          arprot,
   output logic                arvalid,
   input  logic                arready,
   input  logic [ID_WIDTH-1:0] rid,
   input  logic [31:0]         rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,
   output logic                refill_err_resp,
   output logic                refill_err_len
);

   // Counter value of the final (16th) beat of a line.
   localparam logic [3:0] LAST_CNT = 4'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARQ,
      S_RD,
      S_PAD,
      S_DRAIN
   } state_t;

   state_t     state;
   logic [3:0] cnt;

   // The read ID is not checked and the line offset bits are always forced to zero.
   logic unused_ok;
   assign unused_ok = &{1'b0, rid, inst_addr_mmu[5:0]};

   // Fixed AR attributes: single-ID, 16 x 32-bit INCR, non-cacheable instruction fetch.
   assign arid    = ARID_VAL[ID_WIDTH-1:0];
   assign arlen   = 8'(BEATS - 1);
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign arcache = 4'b0000;
   assign arprot  = 3'b100;

   // Refill sequencer with registered handshake and beat outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         cnt             <= 4'd0;
         araddr          <= 32'd0;
         arvalid         <= 1'b0;
         rready          <= 1'b0;
         inst_addr_ok    <= 1'b0;
         inst_read_data  <= 32'd0;
         mmu_valid       <= 1'b0;
         mmu_last        <= 1'b0;
         refill_err_resp <= 1'b0;
         refill_err_len  <= 1'b0;
      end else begin
         inst_addr_ok <= 1'b0;
         mmu_valid    <= 1'b0;
         mmu_last     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (inst_read_req) begin
                  araddr       <= {inst_addr_mmu[31:6], 6'b0};
                  cnt          <= 4'd0;
                  arvalid      <= 1'b1;
                  inst_addr_ok <= 1'b1;
                  state        <= S_ARQ;
               end
            end
            S_ARQ: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= S_RD;
               end
            end
            S_RD: begin
               if (rvalid && rready) begin
                  mmu_valid      <= 1'b1;
                  inst_read_data <= rdata;
                  cnt            <= cnt + 4'd1;
                  if (rresp != 2'b00) begin
                     refill_err_resp <= 1'b1;
                  end
                  if (cnt == LAST_CNT) begin
                     mmu_last <= 1'b1;
                     if (rlast) begin
                        rready <= 1'b0;
                        state  <= S_IDLE;
                     end else begin
                        // Slave overran the line: keep rready high and discard the rest.
                        refill_err_len <= 1'b1;
                        state          <= S_DRAIN;
                     end
                  end else if (rlast) begin
                     // Slave ended early: the cache still gets 16 beats, padded with zeros.
                     refill_err_len <= 1'b1;
                     rready         <= 1'b0;
                     state          <= S_PAD;
                  end
               end
            end
            S_PAD: begin
               mmu_valid      <= 1'b1;
               inst_read_data <= 32'd0;
               cnt            <= cnt + 4'd1;
               if (cnt == LAST_CNT) begin
                  mmu_last <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (rvalid && rready) begin
                  if (rresp != 2'b00) begin
                     refill_err_resp <= 1'b1;
                  end
                  if (rlast) begin
                     rready <= 1'b0;
                     state  <= S_IDLE;
                  end
               end
            end
            default: begin
               arvalid <= 1'b0;
               rready  <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
